// File: rtl/tlb_multiport.sv
// Parametrised joint TLB with NSPORT registered search ports, a Random/Wired
// replacement counter and a sequential flush engine. Define TLB_PERF_CNT_EN to add hit/miss counters.
module tlb_multiport #(
    parameter int TLBNUM = 16,
    parameter int NSPORT = 2,
    parameter int ASID_W = 8,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic                     clk,
`ifdef TLB_PERF_CNT_EN
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt,
`endif
    input  logic                     resetn,
    input  logic [NSPORT-1:0]        s_req,
    input  logic [19*NSPORT-1:0]     s_vpn2,
    input  logic [NSPORT-1:0]        s_odd_page,
    input  logic [ASID_W*NSPORT-1:0] s_asid,
    output logic [NSPORT-1:0]        s_rvalid,
    output logic [NSPORT-1:0]        s_found,
    output logic [IW*NSPORT-1:0]     s_index,
    output logic [20*NSPORT-1:0]     s_pfn,
    output logic [3*NSPORT-1:0]      s_c,
    output logic [NSPORT-1:0]        s_d,
    output logic [NSPORT-1:0]        s_v,
    input  logic                     we,
    input  logic                     w_random,
    input  logic [IW-1:0]            w_index,
    input  logic [18:0]              w_vpn2,
    input  logic [ASID_W-1:0]        w_asid,
    input  logic                     w_g,
    input  logic [19:0]              w_pfn0,
    input  logic [2:0]               w_c0,
    input  logic                     w_d0,
    input  logic                     w_v0,
    input  logic [19:0]              w_pfn1,
    input  logic [2:0]               w_c1,
    input  logic                     w_d1,
    input  logic                     w_v1,
    input  logic [IW-1:0]            r_index,
    output logic [18:0]              r_vpn2,
    output logic [ASID_W-1:0]        r_asid,
    output logic                     r_g,
    output logic [19:0]              r_pfn0,
    output logic [2:0]               r_c0,
    output logic                     r_d0,
    output logic                     r_v0,
    output logic [19:0]              r_pfn1,
    output logic [2:0]               r_c1,
    output logic                     r_d1,
    output logic                     r_v1,
    input  logic                     wired_we,
    input  logic [IW-1:0]            wired_wdata,
    output logic [IW-1:0]            random_idx,
    input  logic                     flush_req,
    input  logic                     flush_asid_only,
    input  logic [ASID_W-1:0]        flush_asid,
    output logic                     flush_busy
);

    localparam logic [IW-1:0] LAST = IW'(TLBNUM - 1);

    typedef enum logic {IDLE, WALK} state_t;

    logic [18:0]       tlb_vpn2 [TLBNUM];
    logic [ASID_W-1:0] tlb_asid [TLBNUM];
    logic              tlb_g    [TLBNUM];
    logic [19:0]       tlb_pfn0 [TLBNUM];
    logic [2:0]        tlb_c0   [TLBNUM];
    logic              tlb_d0   [TLBNUM];
    logic              tlb_v0   [TLBNUM];
    logic [19:0]       tlb_pfn1 [TLBNUM];
    logic [2:0]        tlb_c1   [TLBNUM];
    logic              tlb_d1   [TLBNUM];
    logic              tlb_v1   [TLBNUM];

    state_t            state;
    logic [IW-1:0]     ptr;
    logic              f_all;
    logic [ASID_W-1:0] f_asid;
    logic [IW-1:0]     wired;
    logic [IW-1:0]     wr_idx;
    logic              hit  [NSPORT];
    logic [IW-1:0]     hidx [NSPORT];

    assign wr_idx = w_random ? random_idx : w_index;

    // Flush walk clears one entry per cycle; writes are locked out while busy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                tlb_vpn2[i] <= '0;
                tlb_asid[i] <= '0;
                tlb_g[i]    <= 1'b0;
                tlb_pfn0[i] <= '0;
                tlb_c0[i]   <= '0;
                tlb_d0[i]   <= 1'b0;
                tlb_v0[i]   <= 1'b0;
                tlb_pfn1[i] <= '0;
                tlb_c1[i]   <= '0;
                tlb_d1[i]   <= 1'b0;
                tlb_v1[i]   <= 1'b0;
            end
        end else begin
            if (we && !flush_busy) begin
                tlb_vpn2[wr_idx] <= w_vpn2;
                tlb_asid[wr_idx] <= w_asid;
                tlb_g[wr_idx]    <= w_g;
                tlb_pfn0[wr_idx] <= w_pfn0;
                tlb_c0[wr_idx]   <= w_c0;
                tlb_d0[wr_idx]   <= w_d0;
                tlb_v0[wr_idx]   <= w_v0;
                tlb_pfn1[wr_idx] <= w_pfn1;
                tlb_c1[wr_idx]   <= w_c1;
                tlb_d1[wr_idx]   <= w_d1;
                tlb_v1[wr_idx]   <= w_v1;
            end
            if (state == WALK && (f_all || (!tlb_g[ptr] && tlb_asid[ptr] == f_asid))) begin
                tlb_v0[ptr] <= 1'b0;
                tlb_v1[ptr] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            ptr        <= '0;
            f_all      <= 1'b0;
            f_asid     <= '0;
            flush_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state      <= WALK;
                        ptr        <= '0;
                        f_all      <= !flush_asid_only;
                        f_asid     <= flush_asid;
                        flush_busy <= 1'b1;
                    end
                end
                WALK: begin
                    ptr <= ptr + IW'(1);
                    if (ptr == LAST) begin
                        state      <= IDLE;
                        flush_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Random never drops below Wired; a Wired write restarts it from the top
    always_ff @(posedge clk) begin
        if (!resetn) begin
            random_idx <= LAST;
            wired      <= '0;
        end else if (wired_we) begin
            random_idx <= LAST;
            wired      <= wired_wdata;
        end else if (random_idx <= wired) begin
            random_idx <= LAST;
        end else begin
            random_idx <= random_idx - IW'(1);
        end
    end

    // Scanning downwards leaves the lowest matching index as the winner
    always_comb begin
        for (int p = 0; p < NSPORT; p++) begin
            hit[p]  = 1'b0;
            hidx[p] = '0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (tlb_vpn2[i] == s_vpn2[19*p +: 19] &&
                    (tlb_g[i] || tlb_asid[i] == s_asid[ASID_W*p +: ASID_W])) begin
                    hit[p]  = 1'b1;
                    hidx[p] = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_rvalid <= '0;
            s_found  <= '0;
            s_index  <= '0;
            s_pfn    <= '0;
            s_c      <= '0;
            s_d      <= '0;
            s_v      <= '0;
        end else begin
            for (int p = 0; p < NSPORT; p++) begin
                s_rvalid[p] <= s_req[p];
                if (s_req[p] && hit[p]) begin
                    s_found[p]          <= 1'b1;
                    s_index[IW*p +: IW] <= hidx[p];
                    if (s_odd_page[p]) begin
                        s_pfn[20*p +: 20] <= tlb_pfn1[hidx[p]];
                        s_c[3*p +: 3]     <= tlb_c1[hidx[p]];
                        s_d[p]            <= tlb_d1[hidx[p]];
                        s_v[p]            <= tlb_v1[hidx[p]];
                    end else begin
                        s_pfn[20*p +: 20] <= tlb_pfn0[hidx[p]];
                        s_c[3*p +: 3]     <= tlb_c0[hidx[p]];
                        s_d[p]            <= tlb_d0[hidx[p]];
                        s_v[p]            <= tlb_v0[hidx[p]];
                    end
                end else begin
                    s_found[p]          <= 1'b0;
                    s_index[IW*p +: IW] <= '0;
                    s_pfn[20*p +: 20]   <= '0;
                    s_c[3*p +: 3]       <= '0;
                    s_d[p]              <= 1'b0;
                    s_v[p]              <= 1'b0;
                end
            end
        end
    end

    assign r_vpn2 = tlb_vpn2[r_index];
    assign r_asid = tlb_asid[r_index];
    assign r_g    = tlb_g[r_index];
    assign r_pfn0 = tlb_pfn0[r_index];
    assign r_c0   = tlb_c0[r_index];
    assign r_d0   = tlb_d0[r_index];
    assign r_v0   = tlb_v0[r_index];
    assign r_pfn1 = tlb_pfn1[r_index];
    assign r_c1   = tlb_c1[r_index];
    assign r_d1   = tlb_d1[r_index];
    assign r_v1   = tlb_v1[r_index];

`ifdef TLB_PERF_CNT_EN
    logic [2:0]  n_hit;
    logic [2:0]  n_miss;
    logic [32:0] hit_sum;
    logic [32:0] miss_sum;

    always_comb begin
        n_hit  = '0;
        n_miss = '0;
        for (int p = 0; p < NSPORT; p++) begin
            if (s_rvalid[p]) begin
                if (s_found[p]) n_hit = n_hit + 3'd1;
                else            n_miss = n_miss + 3'd1;
            end
        end
    end

    assign hit_sum  = {1'b0, hit_cnt} + {30'b0, n_hit};
    assign miss_sum = {1'b0, miss_cnt} + {30'b0, n_miss};

    // Carry out of bit 31 means the counter would wrap, so pin it at all-ones
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            hit_cnt  <= hit_sum[32]  ? '1 : hit_sum[31:0];
            miss_cnt <= miss_sum[32] ? '1 : miss_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_tlb_multiport.sv
// Self-checking bench for tlb_multiport (TLBNUM=16, NSPORT=2, ASID_W=8).
// Lookup expectations are queued when driven and popped one cycle later.
module tb_tlb_multiport;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  s_req;
    logic [37:0] s_vpn2;
    logic [1:0]  s_odd_page;
    logic [15:0] s_asid;
    logic [1:0]  s_rvalid, s_found, s_d, s_v;
    logic [7:0]  s_index;
    logic [39:0] s_pfn;
    logic [5:0]  s_c;
    logic        we, w_random, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [3:0]  w_index, r_index, wired_wdata, random_idx;
    logic [18:0] w_vpn2, r_vpn2;
    logic [7:0]  w_asid, r_asid, flush_asid;
    logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
    logic [2:0]  w_c0, w_c1, r_c0, r_c1;
    logic        r_g, r_d0, r_v0, r_d1, r_v1;
    logic        wired_we, flush_req, flush_asid_only, flush_busy;
`ifdef TLB_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int          port;
        logic [18:0] vpn2;
        logic        odd;
        logic [7:0]  asid;
        logic        found;
        logic [3:0]  idx;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } vec_t;

    vec_t vecs [7];
    vec_t sbq [$];

    always #5 clk = ~clk;

    tlb_multiport dut (
        .clk(clk),
`ifdef TLB_PERF_CNT_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .resetn(resetn), .s_req(s_req), .s_vpn2(s_vpn2), .s_odd_page(s_odd_page),
        .s_asid(s_asid), .s_rvalid(s_rvalid), .s_found(s_found), .s_index(s_index),
        .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
        .we(we), .w_random(w_random), .w_index(w_index), .w_vpn2(w_vpn2),
        .w_asid(w_asid), .w_g(w_g), .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0),
        .w_v0(w_v0), .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .wired_we(wired_we), .wired_wdata(wired_wdata), .random_idx(random_idx),
        .flush_req(flush_req), .flush_asid_only(flush_asid_only),
        .flush_asid(flush_asid), .flush_busy(flush_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic write_entry(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                               input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                               input logic d0, input logic v0, input logic [19:0] pfn1,
                               input logic [2:0] c1, input logic d1, input logic v1, input logic rnd);
        we = 1'b1; w_random = rnd; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
        tick();
        we = 1'b0; w_random = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t e);
        int p;
        p = e.port;
        s_req[p]            = 1'b1;
        s_vpn2[19*p +: 19]  = e.vpn2;
        s_odd_page[p]       = e.odd;
        s_asid[8*p +: 8]    = e.asid;
        sbq.push_back(e);
    endtask

    task automatic check_scoreboard();
        vec_t e;
        int   p;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            p = e.port;
            check_output($sformatf("p%0d rvalid", p), 32'(s_rvalid[p]), 32'd1);
            check_output($sformatf("p%0d found vpn2=%0h", p, e.vpn2), 32'(s_found[p]), 32'(e.found));
            check_output($sformatf("p%0d index", p), 32'(s_index[4*p +: 4]), 32'(e.idx));
            check_output($sformatf("p%0d pfn", p), 32'(s_pfn[20*p +: 20]), 32'(e.pfn));
            check_output($sformatf("p%0d c", p), 32'(s_c[3*p +: 3]), 32'(e.c));
            check_output($sformatf("p%0d d", p), 32'(s_d[p]), 32'(e.d));
            check_output($sformatf("p%0d v", p), 32'(s_v[p]), 32'(e.v));
        end
    endtask

    initial begin
        logic [3:0] rnd_m, wired_m;
        int cnt;
        vec_t e0, e1;

        vecs[0] = '{0, 19'h12345, 1'b1, 8'h05, 1'b1, 4'd3, 20'h00BBB, 3'd3, 1'b1, 1'b1};
        vecs[1] = '{0, 19'h12345, 1'b0, 8'h05, 1'b1, 4'd3, 20'h00AAA, 3'd2, 1'b0, 1'b1};
        vecs[2] = '{1, 19'h12345, 1'b1, 8'h06, 1'b0, 4'd0, 20'h00000, 3'd0, 1'b0, 1'b0};
        vecs[3] = '{1, 19'h00777, 1'b0, 8'h55, 1'b1, 4'd5, 20'h12121, 3'd5, 1'b1, 1'b1};
        vecs[4] = '{0, 19'h00777, 1'b1, 8'h00, 1'b1, 4'd5, 20'h34343, 3'd1, 1'b0, 1'b0};
        vecs[5] = '{1, 19'h00778, 1'b0, 8'h09, 1'b0, 4'd0, 20'h00000, 3'd0, 1'b0, 1'b0};
        vecs[6] = '{0, 19'h0ABCD, 1'b1, 8'h01, 1'b1, 4'd7, 20'h22222, 3'd0, 1'b0, 1'b1};

        resetn = 1'b0; s_req = '0; s_vpn2 = '0; s_odd_page = '0; s_asid = '0;
        we = 1'b0; w_random = 1'b0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
        w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
        w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
        r_index = '0; wired_we = 1'b0; wired_wdata = '0;
        flush_req = 1'b0; flush_asid_only = 1'b0; flush_asid = '0;
        tick();
        tick();
        resetn = 1'b1;

        check_output("reset random_idx", 32'(random_idx), 32'd15);
        check_output("reset s_rvalid", 32'(s_rvalid), 32'd0);
        check_output("reset s_found", 32'(s_found), 32'd0);
        check_output("reset flush_busy", 32'(flush_busy), 32'd0);
        check_output("reset r_v0/r_v1", 32'({r_v0, r_v1}), 32'd0);

        // Random counts down from 15 to Wired=0 and wraps
        rnd_m = 4'd15; wired_m = 4'd0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            rnd_m = (rnd_m == wired_m) ? 4'd15 : rnd_m - 4'd1;
            check_output($sformatf("random step %0d", k), 32'(random_idx), 32'(rnd_m));
        end
        wired_we = 1'b1; wired_wdata = 4'd4;
        tick();
        wired_we = 1'b0;
        rnd_m = 4'd15; wired_m = 4'd4;
        check_output("random after wired_we", 32'(random_idx), 32'd15);
        for (int k = 1; k <= 13; k++) begin
            tick();
            rnd_m = (rnd_m == wired_m) ? 4'd15 : rnd_m - 4'd1;
            check_output($sformatf("wired=4 step %0d", k), 32'(random_idx), 32'(rnd_m));
        end

        // TLBWR lands at random_idx=7, w_index is ignored
        for (int n = 0; n < 20 && random_idx !== 4'd7; n++) tick();
        check_output("random reaches 7", 32'(random_idx), 32'd7);
        write_entry(4'd0, 19'h0ABCD, 8'h01, 1'b0, 20'h11111, 3'd0, 1'b0, 1'b1,
                    20'h22222, 3'd0, 1'b0, 1'b1, 1'b1);
        r_index = 4'd7; #1;
        check_output("tlbwr r_vpn2[7]", 32'(r_vpn2), 32'h0ABCD);
        check_output("tlbwr r_pfn1[7]", 32'(r_pfn1), 32'h22222);
        check_output("tlbwr r_asid[7]", 32'(r_asid), 32'h01);
        r_index = 4'd0; #1;
        check_output("tlbwr idx0 untouched", 32'(r_v0), 32'd0);

        write_entry(4'd3, 19'h12345, 8'h05, 1'b0, 20'h00AAA, 3'd2, 1'b0, 1'b1,
                    20'h00BBB, 3'd3, 1'b1, 1'b1, 1'b0);
        write_entry(4'd5, 19'h00777, 8'h09, 1'b1, 20'h12121, 3'd5, 1'b1, 1'b1,
                    20'h34343, 3'd1, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 7; k++) begin
            apply_stimulus(vecs[k]);
            tick();
            s_req = '0;
            check_scoreboard();
        end
        tick();
        check_output("rvalid one cycle only", 32'(s_rvalid), 32'd0);

        // Duplicate global entries: lowest index wins; same-cycle rewrite not visible
        write_entry(4'd2, 19'h3C3C3, 8'h00, 1'b1, 20'h02020, 3'd0, 1'b0, 1'b1,
                    20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        write_entry(4'd9, 19'h3C3C3, 8'h00, 1'b1, 20'h09090, 3'd0, 1'b0, 1'b1,
                    20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        e0 = '{0, 19'h3C3C3, 1'b0, 8'h10, 1'b1, 4'd2, 20'h02020, 3'd0, 1'b0, 1'b1};
        e1 = '{1, 19'h3C3C3, 1'b0, 8'h20, 1'b1, 4'd2, 20'h02020, 3'd0, 1'b0, 1'b1};
        apply_stimulus(e0);
        apply_stimulus(e1);
        write_entry(4'd2, 19'h3C3C3, 8'h00, 1'b1, 20'h0F0F0, 3'd0, 1'b0, 1'b1,
                    20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        s_req = '0;
        check_scoreboard();
        e0.pfn = 20'h0F0F0;
        apply_stimulus(e0);
        tick();
        s_req = '0;
        check_scoreboard();

        // ASID flush: entries with i%4==0 are non-global asid 0x22 and must die
        for (int i = 0; i < 16; i++) begin
            write_entry(4'(i), 19'(32'h100 + i), (i % 4 == 2) ? 8'h33 : 8'h22, (i % 2 == 1),
                        20'(32'h500 + i), 3'd0, 1'b0, 1'b1, 20'(32'h600 + i), 3'd0, 1'b0, 1'b1, 1'b0);
        end
        flush_req = 1'b1; flush_asid_only = 1'b1; flush_asid = 8'h22;
        tick();
        flush_req = 1'b0;
        we = 1'b1; w_index = 4'd2; w_vpn2 = 19'h07777; w_v0 = 1'b1; w_v1 = 1'b1; w_g = 1'b0;
        cnt = 0;
        while (flush_busy === 1'b1 && cnt < 40) begin
            cnt++;
            flush_req = (cnt == 3);
            flush_asid_only = 1'b0;
            tick();
        end
        flush_req = 1'b0; we = 1'b0;
        check_output("flush busy cycles", 32'(cnt), 32'd16);
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i);
            tick();
            check_output($sformatf("asid flush v0/v1 [%0d]", i), 32'({r_v0, r_v1}),
                         (i % 4 == 0) ? 32'd0 : 32'd3);
        end
        r_index = 4'd2; #1;
        check_output("write during flush ignored", 32'(r_vpn2), 32'h102);

        // Reset in the middle of a full flush
        flush_req = 1'b1; flush_asid_only = 1'b0;
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check_output("mid-flush busy", 32'(flush_busy), 32'd1);
        resetn = 1'b0;
        tick();
        check_output("reset mid-flush busy", 32'(flush_busy), 32'd0);
        check_output("reset mid-flush random", 32'(random_idx), 32'd15);
        resetn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i);
            tick();
            check_output($sformatf("reset mid-flush v [%0d]", i), 32'({r_v0, r_v1}), 32'd0);
        end

`ifdef TLB_PERF_CNT_EN
        write_entry(4'd1, 19'h04444, 8'h00, 1'b1, 20'h1, 3'd0, 1'b0, 1'b1,
                    20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        s_req = 2'b11; s_vpn2 = {19'h04444, 19'h04444};
        tick();
        s_req = 2'b11; s_vpn2 = {19'h05555, 19'h04444};
        tick();
        s_req = 2'b01; s_vpn2 = {19'h05555, 19'h05555};
        tick();
        s_req = '0;
        tick();
        tick();
        check_output("hit_cnt", hit_cnt, 32'd3);
        check_output("miss_cnt", miss_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tlb_multiport.md
Name: tlb_multiport

Overview:
Parametrised successor to the fixed 16-entry, two-search-port TLB used by the MIPS pipeline: an N-search-port, TLBNUM-entry joint TLB.
- Search results are registered (1-cycle latency), so IF, EXE and any future ports see a timing-clean result.
- Adds a hardware Random/Wired replacement counter for TLBWR, and a sequential flush engine that invalidates all entries or ASID-matched non-global entries.
- Sits beside the pipeline stages in mycpu; the WB stage drives its write, read, wired and flush controls.

Parameters:
TLBNUM, 16, entry count; power of two, 4..64; IW = $clog2(TLBNUM)
NSPORT, 2, number of search ports, 1..4
ASID_W, 8, ASID width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
s_req  in  NSPORT  per-port lookup request
s_vpn2  in  19*NSPORT  VA[31:13] per port, port k at [19k+18:19k]
s_odd_page  in  NSPORT  VA[12] per port
s_asid  in  ASID_W*NSPORT  ASID per port
s_rvalid  out  NSPORT  result valid, one cycle after s_req
s_found  out  NSPORT  hit
s_index  out  IW*NSPORT  hit index
s_pfn  out  20*NSPORT  selected pfn
s_c  out  3*NSPORT  selected cache attr
s_d  out  NSPORT  selected dirty
s_v  out  NSPORT  selected valid
we  in  1  write strobe
w_random  in  1  1: write at random_idx (TLBWR); 0: at w_index (TLBWI)
w_index  in  IW  write index
w_vpn2  in  19  write VPN2
w_asid  in  ASID_W  write ASID
w_g  in  1  write global
w_pfn0 / w_pfn1  in  20 each  even/odd PFN
w_c0 / w_c1  in  3 each  even/odd cache attr
w_d0 / w_d1 / w_v0 / w_v1  in  1 each  dirty/valid bits
r_index  in  IW  read index
r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  out  per field  combinational read of entry r_index
wired_we  in  1  load Wired
wired_wdata  in  IW  new Wired value
random_idx  out  IW  current Random value
flush_req  in  1  start flush (pulse)
flush_asid_only  in  1  sampled with flush_req: 1 = ASID flush, 0 = all
flush_asid  in  ASID_W  sampled with flush_req
flush_busy  out  1  flush in progress

Behaviour:
Reset (resetn=0 at posedge):
- all v0/v1=0; other entry fields cleared to 0
- random_idx=TLBNUM-1, Wired=0, FSM IDLE
- s_rvalid=0, s_found=0, flush_busy=0

Search:
- Match condition: vpn2 equal AND (g OR asid equal).
- Lookup is evaluated on the array contents at the posedge where s_req=1; result is registered, and s_rvalid=1 in the next cycle only.
- A write in the same cycle is not visible to that lookup.
- Odd page selects the pfn1/c1/d1/v1 set, even page the pfn0 set.
- Multiple hits: lowest index wins.
- Miss: found=0, index/pfn/c/d/v all 0.
- Ports are fully independent.

Write:
- Entry updated at the posedge with we=1, at index w_random ? random_idx : w_index.
- we is ignored while flush_busy=1.

Read:
- Purely combinational from r_index.
- Shows new data the cycle after a write.

Random:
- Decrements every cycle; when equal to Wired, next value is TLBNUM-1.
- wired_we=1: Wired<=wired_wdata and random_idx<=TLBNUM-1 (priority over decrement).
- Wired>=TLBNUM-1 holds random_idx at TLBNUM-1.

Flush FSM:
- IDLE -> WALK on flush_req: latch mode and ASID, ptr=0, flush_busy=1.
- WALK: each cycle, entry[ptr] gets v0=v1=0 if mode=all, or if (!g AND asid==latched). ptr++.
- After ptr=TLBNUM-1 -> IDLE, flush_busy=0. Total TLBNUM busy cycles.
- flush_req during WALK is ignored.
- Searches during WALK proceed on the partially flushed array.
- Reset during WALK aborts and applies reset values.

Optional Feature:
TLB_PERF_CNT_EN
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
- Each cycle, each counter increments by the number of ports whose s_rvalid=1 with found=1 (hit) or found=0 (miss).
- Counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports absent, no counter logic.

Test Plan:
1. Write idx 3 {vpn2=0x12345, asid=0x05, g=0, pfn0=0x00AAA, v0=1, pfn1=0x00BBB, v1=1}; port0 lookup vpn2=0x12345, odd=1, asid=0x05 -> next cycle s_rvalid=1, found=1, index=3, pfn=0x00BBB, v=1; asid=0x06 -> found=0.
2. Entries 2 and 9 both g=1 with the same vpn2; lookup on all ports simultaneously -> every port index=2; same-cycle rewrite of entry 2 -> that lookup still returns the old pfn.
3. After reset, random_idx counts 15,14,...,0,15; wired_we with 4 -> next random_idx=15, then decrements to 4 and wraps to 15; we with w_random=1 when random_idx=7 -> r_index=7 shows the written data.
4. Fill 16 entries, half g=1 and half asid=0x22; flush_req with asid_only=1, asid=0x22 -> flush_busy high for exactly 16 cycles; only non-global asid=0x22 entries have v0=v1=0; we during busy has no effect.
5. Pulse resetn=0 mid-flush at ptr=5 -> flush_busy=0 next cycle, all entries invalid, random_idx=15.
6. With TLB_PERF_CNT_EN: 3 hits and 2 misses over 2 ports -> hit_cnt=3, miss_cnt=2; preload near-saturation via a long run -> holds at 0xFFFFFFFF.
